// File: rtl/baugh_wooley_array_multiplier.sv
// ============================================================================
// Module   : baugh_wooley_array_multiplier
// Brief    : Signed WIDTHxWIDTH Baugh-Wooley carry-save array multiplier with
//            ripple final adder and registered 2*WIDTH-bit product.
//            Define BWM_INPUT_REG_EN to register operands ahead of the array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bw_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module baugh_wooley_array_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);
  localparam int PW = 2 * WIDTH;
  // Correction term 2^WIDTH + 2^(2*WIDTH-1)
  localparam logic [PW-1:0] c_corr = {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  logic             w_valid;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [PW-1:0]    w_prod;
  logic             out_valid_q;
  logic [PW-1:0]    product_q;

`ifdef BWM_INPUT_REG_EN
  logic             in_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      in_valid_q <= in_valid;
      a_q        <= a;
      b_q        <= b;
    end
  end

  assign w_valid = in_valid_q;
  assign w_a     = a_q;
  assign w_b     = b_q;
`else
  assign w_valid = in_valid;
  assign w_a     = a;
  assign w_b     = b;
`endif

  // Row j adds partial products a[i]&b[j] at weight i+j into the carry-save pair.
  for (genvar j = 0; j < WIDTH; j++) begin : g_stage
    logic [PW-1:0] w_sin;
    logic [PW-1:0] w_cin;
    logic [PW-1:0] w_pp;
    logic [PW-1:0] w_sout;
    logic [PW-1:0] w_cout;
    logic [PW-2:0] w_cy;

    if (j == 0) begin : g_first
      assign w_sin = c_corr;
      assign w_cin = '0;
    end else begin : g_next
      assign w_sin = g_stage[j-1].w_sout;
      assign w_cin = g_stage[j-1].w_cout;
    end

    for (genvar k = 0; k < PW; k++) begin : g_bit
      if ((k >= j) && (k < j + WIDTH)) begin : g_pp
        if (((k - j) == WIDTH - 1) != (j == WIDTH - 1)) begin : g_inv
          assign w_pp[k] = ~(w_a[k-j] & w_b[j]);
        end else begin : g_pos
          assign w_pp[k] = w_a[k-j] & w_b[j];
        end
      end else begin : g_zero
        assign w_pp[k] = 1'b0;
      end

      if (k < PW - 1) begin : g_fa
        bw_full_adder u_fa (
          .a_i  (w_sin[k]),
          .b_i  (w_cin[k]),
          .ci_i (w_pp[k]),
          .s_o  (w_sout[k]),
          .co_o (w_cy[k])
        );
      end else begin : g_msb
        assign w_sout[k] = w_sin[k] ^ w_cin[k] ^ w_pp[k];
      end
    end

    assign w_cout = {w_cy, 1'b0};
  end

  // Ripple-carry resolution of the final sum/carry rows; carry out of the MSB is dropped.
  for (genvar k = 0; k < PW; k++) begin : g_rca
    logic w_ci;

    if (k == 0) begin : g_lsb
      assign w_ci = 1'b0;
    end else begin : g_mid
      assign w_ci = g_rca[k-1].g_fa.w_co;
    end

    if (k < PW - 1) begin : g_fa
      logic w_co;
      bw_full_adder u_fa (
        .a_i  (g_stage[WIDTH-1].w_sout[k]),
        .b_i  (g_stage[WIDTH-1].w_cout[k]),
        .ci_i (w_ci),
        .s_o  (w_prod[k]),
        .co_o (w_co)
      );
    end else begin : g_msb
      assign w_prod[k] = g_stage[WIDTH-1].w_sout[k] ^ g_stage[WIDTH-1].w_cout[k] ^ w_ci;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      out_valid_q <= w_valid;
      if (w_valid) begin
        product_q <= w_prod;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

`default_nettype wire

// File: tb/tb_baugh_wooley_array_multiplier.sv
// ============================================================================
// Module   : tb_baugh_wooley_array_multiplier
// Brief    : Self-checking bench for baugh_wooley_array_multiplier against a
//            plain signed-multiply reference with a latency-delay queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baugh_wooley_array_multiplier;
`ifdef BWM_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        v;
    logic [63:0] p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;

  exp_t        pipe_q[$];
  logic        exp_valid;
  logic [63:0] exp_prod;

  baugh_wooley_array_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('{v: 1'b0, p: 64'd0});
    exp_valid = 1'b0;
    exp_prod  = 64'd0;
  endtask

  // One clock: drive inputs, advance the reference pipeline, compare outputs.
  task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    in_valid = v;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    pipe_q.push_back('{v: v, p: ref_mul(x, y)});
    e = pipe_q.pop_front();
    exp_valid = e.v;
    if (e.v) exp_prod = e.p;
    chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
    chk({tag, "_prod"}, product, exp_prod);
  endtask

  task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic [63:0] lit, input string tag);
    cycle(1'b1, x, y, tag);
    for (int i = 0; i < LAT - 1; i++) cycle(1'b0, 32'd0, 32'd0, {tag, "_idle"});
    chk({tag, "_lit"}, product, lit);
  endtask

  initial begin
    logic [63:0] neg_lit;
    model_reset();
    #12;
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_prod", product, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed(-32'sd1234, -32'sd456, 64'd562704, "neg_neg");
    directed(-32'sd2147483647, 32'sd2147483647, 64'hC000_0000_FFFF_FFFF, "max_mag");
    neg_lit = -64'sd2049638230889390990;
    directed(32'h5555_5555, 32'hAAAA_AAAA, neg_lit, "alt_bits");
    directed(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min");
    directed(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "min_one");
    directed(32'd0, 32'hDEAD_BEEF, 64'd0, "zero_a");
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "m1_m1");

    // Product must hold while in_valid is low.
    for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, $urandom, "hold");

    for (int i = 0; i < 100; i++) cycle(1'b1, $urandom, $urandom, "stream");
    for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), $urandom, $urandom, "gappy");

    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, $urandom, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_prod", product, 64'd0);
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    @(posedge clk);
    #1;
    chk("in_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("in_rst_prod", product, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, $urandom, "post_rst_idle");
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, $urandom, "post_rst");
    for (int i = 0; i < LAT; i++) cycle(1'b0, 32'd0, 32'd0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/baugh_wooley_array_multiplier.md
# baugh_wooley_array_multiplier

Signed 32×32 two's-complement multiplier built as a Baugh-Wooley carry-save array with a ripple final adder, producing a full-precision 64-bit product. It sits in the datapath as a pipelined arithmetic leaf. It accepts one operand pair per cycle and returns the registered product with fixed latency.

## Interface
- `WIDTH`, default 32: operand width; the product is 2·`WIDTH` bits. Only 32 is verified.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands `a` and `b` are valid this cycle.
- `a`, input, 32: multiplicand, signed two's complement.
- `b`, input, 32: multiplier, signed two's complement.
- `out_valid`, output, 1: `product` is valid this cycle.
- `product`, output, 64: signed product a·b, two's complement.

## Operation
- Partial products are pp[i][j] = a[i] & b[j] for i, j in 0..31.
- The partial product is inverted (~(a[i] & b[j])) when exactly one of i, j equals 31.
- pp[31][31] is not inverted.
- Constant 1 is added at bit 32 and at bit 63. This is the Baugh-Wooley correction term 2^n + 2^(2n-1).
- Reduction uses a rectangular array of full and half adders with carry-save rows.
- The last row is resolved by a ripple-carry adder.
- The sum is taken modulo 2^64. It is exact for all operand pairs, including a = b = −2^31.
- The implementation must not use the `*` operator or `$signed` multiplication. It must instantiate the explicit adder array.
- No backpressure: a new operand pair is accepted every cycle `in_valid` is high.
- When `in_valid` is low, `out_valid` drops on the matching output cycle. `product` holds its last value.

## Timing
- Default latency is 1 cycle. Operands are sampled at edge N and `product`/`out_valid` update at edge N+1.
  - The array and final adder are combinational between the input sampling and the output register.
- Throughput is one result per cycle.
- Reset (`rst_n` = 0) asynchronously forces `product` = 0 and `out_valid` = 0. It also clears any pipeline register in use.
- Reset asserted mid-operation discards in-flight results. No `out_valid` is generated for operands accepted before reset.
- After `rst_n` deasserts, the first operands are accepted on the first rising edge where `in_valid` = 1.

## Configuration
- Macro `BWM_INPUT_REG_EN`.
- When defined:
  - `a`, `b` and `in_valid` are registered before the array, with reset value 0.
  - Latency becomes 2 cycles and throughput is unchanged.
- When undefined: 1-cycle latency as above.
- Reset behaviour is identical in both builds.

## Test plan
- a = −1234, b = −456, in_valid = 1 → after latency: product = 562704 (0x0000_0000_0008_9610), out_valid = 1.
- a = −2147483647, b = 2147483647 → product = 0xC000_0000_FFFF_FFFF.
- a = 0x5555_5555, b = 0xAAAA_AAAA → product = −2049638230889390990.
- Corner cases:
  - a = b = 0x8000_0000 → product = 0x4000_0000_0000_0000.
  - a = 0x8000_0000, b = 1 → product = 0xFFFF_FFFF_8000_0000.
  - a = 0, b = anything → product = 0.
- Streaming:
  - Back-to-back in_valid for 100 random pairs → each product equals the reference signed multiply, in order, with out_valid continuous.
  - Assert rst_n low mid-stream → product = 0 and out_valid = 0 immediately, with no stale result after release.
